// File: rtl/keypad_entry.sv
// keypad_entry: 4x4 keypad scanner with debounce and a four-digit entry history (optional backspace on key E via KEYPAD_BACKSPACE_EN)
module keypad_entry #(
    parameter int SCAN_DIV     = 50000,
    parameter int DEBOUNCE_CNT = 500000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [3:0] row,
    output logic [3:0] col,
    output logic [3:0] dig1,
    output logic [3:0] dig2,
    output logic [3:0] dig3,
    output logic [3:0] dig4,
    output logic [3:0] key_code,
    output logic       key_valid
);
    localparam int SW = $clog2(SCAN_DIV);
    localparam int DW = $clog2(DEBOUNCE_CNT);
    localparam logic [SW-1:0] SLOT_MAX = SW'(SCAN_DIV - 1);
    localparam logic [DW-1:0] DEB_MAX  = DW'(DEBOUNCE_CNT - 1);

    typedef enum logic [1:0] {SCAN, DEBOUNCE, RELEASE} state_t;

    state_t        r_state, w_state_n;
    logic [3:0]    r_meta, r_rs, r_pat, r_col;
    logic [1:0]    r_c, r_r;
    logic [SW-1:0] r_slot;
    logic [DW-1:0] r_deb;
    logic [3:0]    r_dig1, r_dig2, r_dig3, r_dig4, r_key_code;
    logic          r_key_valid;

    logic [3:0] w_low, w_code;
    logic [1:0] w_ridx;
    logic       w_single, w_slot_end, w_deb_end, w_match, w_idle, w_bs;
    logic       w_latch, w_adv, w_accept, w_home, w_deb_inc, w_deb_clr;

    assign w_low      = ~r_rs;
    assign w_single   = (w_low != 4'd0) && ((w_low & (w_low - 4'd1)) == 4'd0);
    assign w_ridx     = w_low[1] ? 2'd1 : w_low[2] ? 2'd2 : w_low[3] ? 2'd3 : 2'd0;
    assign w_slot_end = (r_slot == SLOT_MAX);
    assign w_deb_end  = (r_deb == DEB_MAX);
    assign w_match    = (r_rs == r_pat);
    assign w_idle     = (r_rs == 4'b1111);
    assign w_code     = {r_r, r_c};
`ifdef KEYPAD_BACKSPACE_EN
    assign w_bs       = (w_code == 4'hE);
`else
    assign w_bs       = 1'b0;
`endif

    // two-flop synchronizer for the asynchronous row inputs
    always_ff @(posedge clk) begin
        if (reset) begin
            r_meta <= 4'b1111;
            r_rs   <= 4'b1111;
        end else begin
            r_meta <= row;
            r_rs   <= r_meta;
        end
    end

    // FSM state register
    always_ff @(posedge clk) begin
        if (reset) r_state <= SCAN;
        else       r_state <= w_state_n;
    end

    // next-state logic and datapath strobes
    always_comb begin
        w_state_n = r_state;
        w_latch   = 1'b0;
        w_adv     = 1'b0;
        w_accept  = 1'b0;
        w_home    = 1'b0;
        w_deb_inc = 1'b0;
        w_deb_clr = 1'b0;
        unique case (r_state)
            SCAN: begin
                if (w_slot_end && w_single) begin
                    w_latch   = 1'b1;
                    w_state_n = DEBOUNCE;
                end else if (w_slot_end) begin
                    w_adv = 1'b1;
                end
            end
            DEBOUNCE: begin
                if (!w_match) begin
                    w_home    = 1'b1;
                    w_state_n = SCAN;
                end else if (w_deb_end) begin
                    w_accept  = 1'b1;
                    w_state_n = RELEASE;
                end else begin
                    w_deb_inc = 1'b1;
                end
            end
            RELEASE: begin
                if (!w_idle) begin
                    w_deb_clr = 1'b1;
                end else if (w_deb_end) begin
                    w_home    = 1'b1;
                    w_state_n = SCAN;
                end else begin
                    w_deb_inc = 1'b1;
                end
            end
            default: begin
                w_home    = 1'b1;
                w_state_n = SCAN;
            end
        endcase
    end

    // counters, column drive, latched key and digit history
    always_ff @(posedge clk) begin
        if (reset) begin
            r_slot      <= '0;
            r_deb       <= '0;
            r_c         <= 2'd0;
            r_col       <= 4'b1110;
            r_r         <= 2'd0;
            r_pat       <= 4'b1111;
            r_key_code  <= 4'd0;
            r_key_valid <= 1'b0;
            r_dig1      <= 4'd0;
            r_dig2      <= 4'd0;
            r_dig3      <= 4'd0;
            r_dig4      <= 4'd0;
        end else begin
            r_key_valid <= w_accept;
            r_slot      <= (w_home || w_adv || w_latch) ? '0 : (r_state == SCAN) ? r_slot + 1'b1 : r_slot;
            r_deb       <= (w_latch || w_accept || w_home || w_deb_clr) ? '0 : w_deb_inc ? r_deb + 1'b1 : r_deb;
            if (w_home) begin
                r_c   <= 2'd0;
                r_col <= 4'b1110;
            end else if (w_adv) begin
                r_c   <= r_c + 2'd1;
                r_col <= {r_col[2:0], r_col[3]};
            end
            if (w_latch) begin
                r_r   <= w_ridx;
                r_pat <= r_rs;
            end
            if (w_accept) begin
                r_key_code <= w_code;
                if (w_bs) begin
                    r_dig1 <= r_dig2;
                    r_dig2 <= r_dig3;
                    r_dig3 <= r_dig4;
                    r_dig4 <= 4'd0;
                end else begin
                    r_dig1 <= w_code;
                    r_dig2 <= r_dig1;
                    r_dig3 <= r_dig2;
                    r_dig4 <= r_dig3;
                end
            end
        end
    end

    assign col       = r_col;
    assign dig1      = r_dig1;
    assign dig2      = r_dig2;
    assign dig3      = r_dig3;
    assign dig4      = r_dig4;
    assign key_code  = r_key_code;
    assign key_valid = r_key_valid;
endmodule

// File: tb/tb_keypad_entry.sv
// tb_keypad_entry: directed checks of keypad_entry with SCAN_DIV=4, DEBOUNCE_CNT=8
module tb_keypad_entry;
    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [15:0] keys = 16'd0;
    logic [3:0]  row, col, dig1, dig2, dig3, dig4, key_code;
    logic        key_valid;
    int          n_checks = 0;
    int          n_err = 0;
    int          pulses = 0;
    int          col_bad = 0;

    keypad_entry #(.SCAN_DIV(4), .DEBOUNCE_CNT(8)) dut (
        .clk(clk), .reset(reset), .row(row), .col(col),
        .dig1(dig1), .dig2(dig2), .dig3(dig3), .dig4(dig4),
        .key_code(key_code), .key_valid(key_valid)
    );

    always #5 clk = ~clk;

    // keypad model: a pressed key pulls its row low while its column is driven low
    always_comb begin
        for (int r = 0; r < 4; r++) begin
            row[r] = 1'b1;
            for (int c = 0; c < 4; c++)
                if (keys[4*r+c] && !col[c]) row[r] = 1'b0;
        end
    end

    // count key_valid pulses shortly after each active edge
    always begin
        @(posedge clk);
        #2;
        if (key_valid) pulses++;
    end

    // watch that at most one column is ever driven
    always @(negedge clk) if (!$onehot0(~col)) col_bad++;

    task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic wait_pulse(output bit ok);
        int p;
        p = pulses;
        ok = 1'b0;
        for (int i = 0; i < 60 && !ok; i++) begin
            tick(1);
            if (pulses != p) ok = 1'b1;
        end
    endtask

    task automatic press_key(input logic [3:0] k);
        bit ok;
        int p;
        p = pulses;
        keys[k] = 1'b1;
        wait_pulse(ok);
        check("press_timeout", 16'(ok), 16'd1);
        check("press_code", 16'(key_code), 16'(k));
        tick(5);
        keys = 16'd0;
        tick(30);
        check("press_count", 16'(pulses - p), 16'd1);
    endtask

    initial begin
        logic [3:0] e;
        bit ok;
        bit seen;
        int p;
        tick(3);
        reset = 1'b0;
        check("rst_col", 16'(col), 16'h000E);
        check("rst_digs", {dig4, dig3, dig2, dig1}, 16'h0000);
        check("rst_kv", 16'(key_valid), 16'd0);
        check("rst_code", 16'(key_code), 16'd0);
        for (int k = 1; k <= 16; k++) begin
            tick(1);
            e = ~(4'd1 << ((k / 4) % 4));
            check("scan_col", 16'(col), 16'(e));
        end

        reset = 1'b1;
        keys[4] = 1'b1;
        tick(2);
        reset = 1'b0;
        for (int k = 1; k <= 12; k++) begin
            tick(1);
            check("latency_kv", 16'(key_valid), 16'(k == 12));
        end
        check("latency_code", 16'(key_code), 16'd4);
        check("latency_dig1", 16'(dig1), 16'd4);
        keys = 16'd0;
        tick(30);

        p = pulses;
        reset = 1'b1;
        keys[4] = 1'b1;
        tick(2);
        reset = 1'b0;
        tick(8);
        reset = 1'b1;
        tick(2);
        check("rst_mid_digs", {dig4, dig3, dig2, dig1}, 16'h0000);
        check("rst_mid_col", 16'(col), 16'h000E);
        keys = 16'd0;
        reset = 1'b0;
        tick(30);
        check("rst_mid_pulses", 16'(pulses - p), 16'd0);

        p = pulses;
        keys[9] = 1'b1;
        tick(40);
        check("hold_col", 16'(col), 16'h000D);
        check("hold_pulses", 16'(pulses - p), 16'd1);
        check("hold_code", 16'(key_code), 16'h9);
        check("hold_dig1", 16'(dig1), 16'h9);
        keys = 16'd0;
        tick(9);
        check("release_hold_col", 16'(col), 16'h000D);
        tick(1);
        check("release_done_col", 16'(col), 16'h000E);
        tick(20);
        check("release_pulses", 16'(pulses - p), 16'd1);

        p = pulses;
        for (int i = 0; i < 6; i++) begin
            keys[3] = 1'b1;
            tick(3);
            keys[3] = 1'b0;
            tick(3);
        end
        check("bounce_pulses", 16'(pulses - p), 16'd0);
        keys[3] = 1'b1;
        wait_pulse(ok);
        check("bounce_timeout", 16'(ok), 16'd1);
        check("bounce_code", 16'(key_code), 16'h3);
        check("bounce_digs", {8'h00, dig2, dig1}, 16'h0093);
        keys = 16'd0;
        tick(30);

        for (int k = 1; k <= 5; k++) press_key(4'(k));
        check("seq_digs", {dig4, dig3, dig2, dig1}, 16'h2345);

        p = pulses;
        seen = 1'b0;
        keys[1] = 1'b1;
        keys[5] = 1'b1;
        for (int i = 0; i < 60; i++) begin
            tick(1);
            if (col == 4'b0111) seen = 1'b1;
        end
        check("multi_pulses", 16'(pulses - p), 16'd0);
        check("multi_scanning", 16'(seen), 16'd1);
        check("multi_digs", {dig4, dig3, dig2, dig1}, 16'h2345);
        keys = 16'd0;
        tick(20);

        press_key(4'hE);
`ifdef KEYPAD_BACKSPACE_EN
        check("key_e_digs", {dig4, dig3, dig2, dig1}, 16'h0234);
`else
        check("key_e_digs", {dig4, dig3, dig2, dig1}, 16'h345E);
`endif
        check("col_onehot", 16'(col_bad), 16'd0);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end
endmodule

// File: doc/keypad_entry.md
KEYPAD_ENTRY -- requirements
Module: keypad_entry

Interface
REQ-001 Parameter SCAN_DIV, default 50000: clock cycles each column is driven during scanning (minimum 4).
REQ-002 Parameter DEBOUNCE_CNT, default 500000: number of consecutive stable cycles needed to accept a press or a release (minimum 2).
REQ-003 clk  input  1  system clock; the block uses this single clock domain only.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 row  input  [3:0]  keypad rows; active-low; pulled up externally; asynchronous to clk.
REQ-006 col  output  [3:0]  keypad columns; active-low; at most one bit low at any time.
REQ-007 dig1, dig2, dig3, dig4  output  [3:0] each  entered digit history; dig1 holds the newest digit; these ports feed the display digit inputs directly.
REQ-008 key_code  output  [3:0]  code of the last accepted key.
REQ-009 key_valid  output  1  one-cycle pulse when a key is accepted.

Function
REQ-010 row SHALL pass through a 2-flop synchronizer; all logic below uses only the synchronized value rs.
REQ-011 FSM states SHALL be SCAN, DEBOUNCE and RELEASE.
REQ-012 SCAN: column c (0..3) SHALL be driven low, i.e. col = ~(1<<c), for SCAN_DIV cycles, counted by slot_cnt from 0 to SCAN_DIV-1.
REQ-013 SCAN, on the cycle slot_cnt==SCAN_DIV-1 with rs exactly one bit low: latch the row index r and column c, clear deb_cnt, go to DEBOUNCE, and keep col unchanged.
REQ-014 SCAN, on the cycle slot_cnt==SCAN_DIV-1 with rs all high or more than one bit low: advance c by one, wrapping 3->0, and clear slot_cnt.
REQ-015 DEBOUNCE: each cycle rs equals the latched pattern, deb_cnt SHALL increment.
REQ-016 DEBOUNCE: on the cycle rs matches and deb_cnt==DEBOUNCE_CNT-1, the next edge SHALL:
  - assert key_valid for exactly one cycle;
  - set key_code = 4*r + c;
  - shift the digits dig4<=dig3, dig3<=dig2, dig2<=dig1, dig1<=key_code (old dig4 is discarded);
  - go to RELEASE with deb_cnt cleared.
REQ-017 DEBOUNCE: any cycle rs differs from the latched pattern (bounce) SHALL return to SCAN at column 0 with slot_cnt and deb_cnt cleared, and no output changes.
REQ-018 RELEASE: col held; deb_cnt increments while rs==4'b1111 and clears on any low bit; on the cycle rs==4'b1111 and deb_cnt==DEBOUNCE_CNT-1 go to SCAN at column 0.
REQ-019 A key held indefinitely SHALL produce exactly one key_valid; no auto-repeat.
REQ-020 Presses in other columns during DEBOUNCE or RELEASE SHALL be invisible, because those columns are not driven.
REQ-021 Counter widths SHALL be $clog2 of the parameter value, with no overflow at maximum count.
REQ-022 key_valid SHALL be registered; all outputs SHALL be glitch-free register outputs.

Reset
REQ-023 On reset the block SHALL set:
  - state = SCAN, c = 0, col = 4'b1110;
  - slot_cnt = 0, deb_cnt = 0, synchronizer flops = 4'b1111;
  - dig1..dig4 = 0, key_code = 0, key_valid = 0.
REQ-024 Reset asserted in any state SHALL take priority over every other transition; an in-progress press is discarded with no key_valid.

Configuration
REQ-025 Macro KEYPAD_BACKSPACE_EN: when defined, an accepted key with code 4'hE SHALL:
  - shift the digits the other way: dig1<=dig2, dig2<=dig3, dig3<=dig4, dig4<=0;
  - still pulse key_valid, with key_code = 4'hE.
REQ-026 Without KEYPAD_BACKSPACE_EN, code 4'hE SHALL be entered as an ordinary digit.

Verification (SCAN_DIV=4, DEBOUNCE_CNT=8)
REQ-027 Reset -> col=4'b1110, dig1..dig4=0, key_valid=0; col then steps 1110->1101->1011->0111->1110, 4 cycles per column.
REQ-028 Press r=2,c=1 clean, held 40 cycles, then released -> exactly one key_valid pulse; key_code=4'h9; dig1=9; col frozen at 4'b1101 until 8 high cycles after release.
REQ-029 Press r=0,c=3 with 3-cycle bounces, then stable -> no key_valid during the bounces; one pulse with key_code=4'h3 after 8 stable cycles.
REQ-030 Keys 1,2,3,4,5 entered in sequence -> dig4..dig1 = 2,3,4,5.
REQ-031 Two rows low together in the driven column -> no key_valid; scanning continues.
REQ-032 With KEYPAD_BACKSPACE_EN, digits 2,3,4,5 then key 4'hE -> dig4..dig1 = 0,2,3,4; without the macro -> 3,4,5,E.
